sipo_rx: RTL and testbench

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_rx_pkg.sv | 26 ++
 rtl/sipo_rx_buf.sv | 61 ++++++
 rtl/sipo_rx.sv | 152 +++++++++++++++
 tb/tb_sipo_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_pkg.sv
// -----------------------------------------------------------------------------
// sipo_rx_pkg
//   Shared definitions for the serial-in / parallel-out receiver:
//   - rx_state_t : framing FSM states
//   - START_LVL / STOP_LVL / IDLE_LVL : bit-level frame constants
//   - cnt_width  : width of the data-bit counter for a given payload size
// -----------------------------------------------------------------------------
package sipo_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

  // The counter must be able to hold DATA_W itself, hence the +1.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/sipo_rx_buf.sv
// -----------------------------------------------------------------------------
// sipo_rx_buf
//   One-entry valid/ready output register for the receiver, plus overrun
//   detection.
//
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   load_req   : a good frame completes this cycle
//   load_data  : payload of that frame
//   err_clr    : synchronous clear of the overrun flag
//   data_ready : consumer accepts the word when data_valid is also high
//   data_out   : held payload
//   data_valid : data_out holds an unconsumed word
//   overrun    : sticky, a good frame arrived while the entry was still full
// -----------------------------------------------------------------------------
module sipo_rx_buf #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [DATA_W-1:0] load_data,
  input  logic              err_clr,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun
);

  logic accept;
  logic can_load;

  // The entry can take a new word when it is empty or is being drained
  // on this very edge; the latter lets a handshake and a new frame coincide.
  assign accept   = data_valid && data_ready;
  assign can_load = !data_valid || data_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (load_req && can_load) begin
      data_out   <= load_data;
      data_valid <= 1'b1;
    end else if (accept) begin
      data_valid <= 1'b0;
    end
  end

  // A dropped word sets overrun; setting wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (load_req && !can_load) begin
      overrun <= 1'b1;
    end else if (err_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// -----------------------------------------------------------------------------
// sipo_rx
//   Serial-in / parallel-out frame receiver. Frame, LSB first:
//   start(1), DATA_W data bits, optional even-parity bit, stop(0).
//   One bit is taken per rising edge with sample_en high.
//
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   serial_in  : serial line, idle level 0
//   sample_en  : qualifies serial_in; all framing state holds when low
//   data_out   : last accepted payload
//   data_valid : data_out holds an unconsumed word
//   data_ready : consumer handshake
//   frame_err  : sticky, stop bit sampled as 1
//   parity_err : sticky, parity mismatch
//   overrun    : sticky, good frame dropped because the buffer was full
//   err_clr    : synchronous clear of the three sticky flags
// -----------------------------------------------------------------------------
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              sample_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  input  logic              err_clr
);

  localparam int CNT_W = cnt_width(DATA_W);

  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              par_acc;

  logic stop_sample;
  logic stop_bad;
  logic par_bad;
  logic good_frame;

  // The frame is judged on the edge that samples its stop bit. par_acc
  // already holds the XOR of the data bits and the parity bit by then.
  assign stop_sample = sample_en && (state == ST_STOP);
  assign stop_bad    = (serial_in != STOP_LVL);
  assign par_bad     = (PARITY_EN != 0) ? par_acc : 1'b0;
  assign good_frame  = stop_sample && !stop_bad && !par_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: nothing moves on an edge where sample_en is low.
  // STOP always returns to IDLE so a start bit can follow immediately.
  always_comb begin
    state_nxt = state;
    if (sample_en) begin
      unique case (state)
        ST_IDLE: begin
          if (serial_in == START_LVL) begin
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Data bits enter at the MSB and shift right, so the first bit ends up
  // in bit 0 after DATA_W samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_acc   <= 1'b0;
    end else if (sample_en) begin
      unique case (state)
        ST_IDLE: begin
          if (serial_in == START_LVL) begin
            bit_cnt <= '0;
            par_acc <= 1'b0;
          end
        end
        ST_DATA: begin
          shift_reg <= {serial_in, shift_reg[DATA_W-1:1]};
          bit_cnt   <= bit_cnt + CNT_W'(1);
          par_acc   <= par_acc ^ serial_in;
        end
        ST_PARITY: begin
          par_acc <= par_acc ^ serial_in;
        end
        default: begin
          bit_cnt <= bit_cnt;
        end
      endcase
    end
  end

  // Framing error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (stop_sample && stop_bad) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
      if (stop_sample && par_bad) begin
        parity_err <= 1'b1;
      end else if (err_clr) begin
        parity_err <= 1'b0;
      end
    end
  end

  sipo_rx_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .load_req   (good_frame),
    .load_data  (shift_reg),
    .err_clr    (err_clr),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_sipo_rx.sv
// -----------------------------------------------------------------------------
// tb_sipo_rx
//   Directed bench for sipo_rx (DATA_W=4, PARITY_EN=1). Expected words are
//   queued as frames are sent; a monitor pops and compares on every
//   handshake. Flags and valid timing are checked inline.
// -----------------------------------------------------------------------------
module tb_sipo_rx;
  import sipo_rx_pkg::*;

  localparam int DATA_W = 4;

  logic              clk;
  logic              reset;
  logic              serial_in;
  logic              sample_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;
  logic              err_clr;

  int total;
  int bad;
  logic [DATA_W-1:0] exp_q[$];

  sipo_rx #(
    .DATA_W    (DATA_W),
    .PARITY_EN (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .sample_en  (sample_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake monitor: a word is consumed at the next rising edge whenever
  // valid and ready are both high in the middle of the cycle.
  always @(negedge clk) begin
    if (reset && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_word: got %0h expected none", data_out);
      end else begin
        check_output("word", 16'(data_out), 16'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_bit(input logic b);
    serial_in = b;
    sample_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) send_bit(IDLE_LVL);
  endtask

  // Start, data LSB first, parity (optionally inverted). After each data
  // bit, gap cycles with sample_en low and a garbage line level.
  task automatic send_frame_head(input logic [DATA_W-1:0] data,
                                 input logic par_flip, input int gap);
    send_bit(START_LVL);
    for (int i = 0; i < DATA_W; i++) begin
      send_bit(data[i]);
      for (int g = 0; g < gap; g++) begin
        serial_in = ~data[i];
        sample_en = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    send_bit((^data) ^ par_flip);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] data,
                            input logic par_flip, input logic stop_bit,
                            input int gap);
    send_frame_head(data, par_flip, gap);
    send_bit(stop_bit);
  endtask

  task automatic pulse_clear();
    err_clr = 1'b1;
    send_bit(IDLE_LVL);
    err_clr = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    serial_in  = IDLE_LVL;
    sample_en  = 1'b0;
    data_ready = 1'b1;
    err_clr    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_data_out", 16'(data_out), 16'h0);
    check_output("rst_valid", 16'(data_valid), 16'h0);
    check_output("rst_flags", {13'h0, frame_err, parity_err, overrun}, 16'h0);
    reset = 1'b1;
    idle_cycles(2);

    $display("[TB] good frame 0x6");
    exp_q.push_back(4'h6);
    send_frame(4'h6, 1'b0, STOP_LVL, 0);
    check_output("f6_valid_on_stop", 16'(data_valid), 16'h1);
    check_output("f6_data", 16'(data_out), 16'h6);
    idle_cycles(1);
    check_output("f6_valid_pulse", 16'(data_valid), 16'h0);
    check_output("f6_flags", {13'h0, frame_err, parity_err, overrun}, 16'h0);

    $display("[TB] parity error");
    send_frame(4'h6, 1'b1, STOP_LVL, 0);
    check_output("par_err_set", 16'(parity_err), 16'h1);
    check_output("par_no_valid", 16'(data_valid), 16'h0);
    pulse_clear();
    check_output("par_err_clr", 16'(parity_err), 16'h0);

    $display("[TB] overrun");
    data_ready = 1'b0;
    exp_q.push_back(4'h3);
    send_frame(4'h3, 1'b0, STOP_LVL, 0);
    send_frame(4'h9, 1'b0, STOP_LVL, 0);
    check_output("ovr_data_held", 16'(data_out), 16'h3);
    check_output("ovr_valid", 16'(data_valid), 16'h1);
    check_output("ovr_flag", 16'(overrun), 16'h1);
    data_ready = 1'b1;
    idle_cycles(1);
    check_output("ovr_drained", 16'(data_valid), 16'h0);
    pulse_clear();
    check_output("ovr_clr", 16'(overrun), 16'h0);

    $display("[TB] handshake coincides with new frame");
    data_ready = 1'b0;
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h7);
    send_frame(4'h1, 1'b0, STOP_LVL, 0);
    send_frame_head(4'h7, 1'b0, 0);
    data_ready = 1'b1;
    send_bit(STOP_LVL);
    check_output("coin_valid", 16'(data_valid), 16'h1);
    check_output("coin_data", 16'(data_out), 16'h7);
    check_output("coin_no_ovr", 16'(overrun), 16'h0);
    idle_cycles(1);

    $display("[TB] frame error with simultaneous clear");
    send_frame_head(4'h6, 1'b0, 0);
    err_clr = 1'b1;
    send_bit(1'b1);
    err_clr = 1'b0;
    check_output("ferr_set_priority", 16'(frame_err), 16'h1);
    check_output("ferr_no_valid", 16'(data_valid), 16'h0);
    pulse_clear();
    check_output("ferr_clr", 16'(frame_err), 16'h0);
    exp_q.push_back(4'hA);
    send_frame(4'hA, 1'b0, STOP_LVL, 0);
    check_output("fA_data", 16'(data_out), 16'hA);
    idle_cycles(1);

    $display("[TB] gated frame 0x5");
    exp_q.push_back(4'h5);
    send_frame(4'h5, 1'b0, STOP_LVL, 3);
    check_output("f5_data", 16'(data_out), 16'h5);
    check_output("f5_valid", 16'(data_valid), 16'h1);
    idle_cycles(1);

    $display("[TB] reset mid-frame");
    send_bit(START_LVL);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b0;
    serial_in = IDLE_LVL;
    repeat (2) @(posedge clk);
    #1;
    check_output("midrst_valid", 16'(data_valid), 16'h0);
    reset = 1'b1;
    idle_cycles(2);
    exp_q.push_back(4'hC);
    send_frame(4'hC, 1'b0, STOP_LVL, 0);
    check_output("fC_data", 16'(data_out), 16'hC);
    idle_cycles(3);
    check_output("fC_flags", {13'h0, frame_err, parity_err, overrun}, 16'h0);
    check_output("queue_empty", 16'(exp_q.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
